// File: rtl/chain_bist.sv
// chain_bist: BIST wrapper for one lane of a shift-register test chain.
// Drives a selectable pattern into the chain. Regenerates the same pattern
// delayed by the chain latency and compares it with the chain output.
// Reports a saturating mismatch count, the index of the first mismatch and a pass flag.
module chain_bist #(
  parameter int unsigned LATENCY = 80,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       pattern_sel,
  input  logic [LEN_W-1:0] run_len,
  output logic             chain_din,
  input  logic             chain_dout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [LEN_W-1:0] first_err_idx
);

  // Latency counter saturates at LATENCY, so it must hold LATENCY+1 values
  localparam int unsigned LAT_W = $clog2(LATENCY + 2);
  localparam logic [6:0]  SEED  = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       sel_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] gen_idx;
  logic [LEN_W-1:0] chk_idx;
  logic [6:0]       gen_lfsr;
  logic [6:0]       chk_lfsr;
  logic [LAT_W-1:0] lat_cnt;

  // PRBS7 x^7+x^6+1, Fibonacci form, shifting toward the MSB
  function automatic logic [6:0] prbs_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  // Pattern bit for a given index: PRBS MSB, constant 0/1, or 1,0,1,... from index 0
  function automatic logic pat_bit(input logic [1:0] sel, input logic prbs_msb,
                                   input logic idx_lsb);
    logic b;
    case (sel)
      2'd0:    b = prbs_msb;
      2'd1:    b = 1'b0;
      2'd2:    b = 1'b1;
      default: b = ~idx_lsb;
    endcase
    return b;
  endfunction

  // Run control, pattern generator and delayed checker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel_q         <= '0;
      len_q         <= '0;
      gen_idx       <= '0;
      chk_idx       <= '0;
      gen_lfsr      <= SEED;
      chk_lfsr      <= SEED;
      lat_cnt       <= '0;
      chain_din     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      case (state)
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            chain_din <= 1'b0;
          end else begin
            // Generator: one bit per cycle until run_len bits have gone out
            if (gen_idx < len_q) begin
              chain_din <= pat_bit(sel_q, gen_lfsr[6], gen_idx[0]);
              gen_idx   <= gen_idx + 1'b1;
              gen_lfsr  <= prbs_next(gen_lfsr);
            end else begin
              chain_din <= 1'b0;
            end
            // Checker: compares only once the first bit has crossed the chain
            if (lat_cnt != LAT_W'(LATENCY)) begin
              lat_cnt <= lat_cnt + 1'b1;
            end else if (chk_idx < len_q) begin
              if (chain_dout != pat_bit(sel_q, chk_lfsr[6], chk_idx[0])) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                // err_count saturates rather than wrapping, so zero means no mismatch yet
                if (err_count == '0) first_err_idx <= chk_idx;
              end
              chk_idx  <= chk_idx + 1'b1;
              chk_lfsr <= prbs_next(chk_lfsr);
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0);
            end
          end
        end
        default: begin
          chain_din <= 1'b0;
          if (start) begin
            sel_q         <= pattern_sel;
            len_q         <= run_len;
            err_count     <= '0;
            first_err_idx <= '0;
            chk_idx       <= '0;
            chk_lfsr      <= SEED;
            lat_cnt       <= '0;
            if (run_len == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              pass     <= 1'b1;
              busy     <= 1'b0;
              gen_idx  <= '0;
              gen_lfsr <= SEED;
            end else begin
              // Bit 0 is driven on the accepting edge itself
              state     <= RUN;
              busy      <= 1'b1;
              done      <= 1'b0;
              pass      <= 1'b0;
              chain_din <= pat_bit(pattern_sel, SEED[6], 1'b0);
              gen_idx   <= LEN_W'(1);
              gen_lfsr  <= prbs_next(SEED);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chain_bist.sv
// tb_chain_bist: directed checks of chain_bist against a behavioural chain model.
module tb_chain_bist;

  localparam int LATENCY = 80;
  localparam int LEN_W   = 16;
  localparam int ERR_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [1:0]       pattern_sel;
  logic [LEN_W-1:0] run_len;
  logic             chain_din;
  logic             chain_dout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [LEN_W-1:0] first_err_idx;

  int checks = 0;
  int errors = 0;

  // Chain model: delay line of dly stages, optional single-bit flip, optional stuck-at-0
  logic [127:0] sr = '0;
  int           dly = 80;
  logic         stuck0 = 1'b0;
  int           flip_edge = -1;
  int           cyc = 0;

  chain_bist #(.LATENCY(LATENCY), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .run_len(run_len),
    .chain_din(chain_din), .chain_dout(chain_dout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // cyc before an edge is that edge's index; at a negedge it names the next edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    sr  <= {sr[126:0], chain_din ^ (cyc == flip_edge)};
  end

  assign chain_dout = stuck0 ? 1'b0 : sr[dly-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns the index k of the accepting edge, ends at the next negedge
  task automatic do_start(input logic [1:0] sel, input int len, output int k);
    pattern_sel = sel;
    run_len     = LEN_W'(len);
    start       = 1'b1;
    k           = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; completion must land on edge k+len+LATENCY+1
  task automatic wait_done(input int k, input int len, input string tag);
    int n = 0;
    while (!done && n < len + LATENCY + 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_time"}, 32'(cyc), 32'(k + len + LATENCY + 2));
  endtask

  initial begin
    int k;
    logic [15:0] cap;
    logic [3:0]  cap4;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern_sel = '0; run_len = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_din", 32'(chain_din), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset in the middle of a run
    do_start(2'd0, 200, k);
    repeat (29) @(negedge clk);
    check("t1_busy_mid", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_pass", 32'(pass), 32'd0);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_idx", 32'(first_err_idx), 32'd0);
    check("t1_din", 32'(chain_din), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_busy_rel", 32'(busy), 32'd0);
    check("t1_done_rel", 32'(done), 32'd0);
    repeat (LATENCY + 2) @(negedge clk);

    // 2: PRBS7 through an ideal chain; first 16 bits from seed 7F are 1111111 000000 1 00
    do_start(2'd0, 200, k);
    for (int i = 0; i < 16; i++) begin
      cap[i] = chain_din;
      @(negedge clk);
    end
    check("t2_prbs_bits", 32'(cap), 32'h207F);
    wait_done(k, 200, "t2");
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_pass", 32'(pass), 32'd1);
    check("t2_err", 32'(err_count), 32'd0);
    check("t2_idx", 32'(first_err_idx), 32'd0);

    // 3: chain corrupts bit 37 only (bit i enters the chain on edge k+i+1)
    do_start(2'd0, 200, k);
    flip_edge = k + 38;
    wait_done(k, 200, "t3");
    flip_edge = -1;
    check("t3_err", 32'(err_count), 32'd1);
    check("t3_idx", 32'(first_err_idx), 32'd37);
    check("t3_pass", 32'(pass), 32'd0);

    // 4: all-1 against a stuck-at-0 chain; 300 mismatches saturate the count
    stuck0 = 1'b1;
    do_start(2'd2, 300, k);
    check("t4_din_one", 32'(chain_din), 32'd1);
    wait_done(k, 300, "t4");
    stuck0 = 1'b0;
    check("t4_err", 32'(err_count), 32'hFF);
    check("t4_idx", 32'(first_err_idx), 32'd0);
    check("t4_pass", 32'(pass), 32'd0);

    // 5: alternating through a 79-cycle chain; compare i sees bit i+1. The final compare
    // (i=99, expected 0) sees the 0 driven after the last bit, so 99 of 100 mismatch.
    dly = 79;
    do_start(2'd3, 100, k);
    for (int i = 0; i < 4; i++) begin
      cap4[i] = chain_din;
      @(negedge clk);
    end
    check("t5_alt_bits", 32'(cap4), 32'h5);
    wait_done(k, 100, "t5");
    dly = 80;
    check("t5_err", 32'(err_count), 32'd99);
    check("t5_idx", 32'(first_err_idx), 32'd0);
    check("t5_pass", 32'(pass), 32'd0);

    // 6: ignored start while busy, abort (winning over start), then zero-length run
    do_start(2'd0, 200, k);
    repeat (9) @(negedge clk);
    run_len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_busy_after_start", 32'(busy), 32'd1);
    repeat (39) @(negedge clk);
    check("t6_abort_edge", 32'(cyc), 32'(k + 50));
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_din", 32'(chain_din), 32'd0);
    check("t6_err_hold", 32'(err_count), 32'd0);
    pattern_sel = 2'd0; run_len = '0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t6_zero_done", 32'(done), 32'd1);
    check("t6_zero_pass", 32'(pass), 32'd1);
    check("t6_zero_busy", 32'(busy), 32'd0);
    repeat (LATENCY + 2) @(negedge clk);
    // restart from DONE; a start at k+10 carrying run_len=5 must not shorten the run
    do_start(2'd0, 20, k);
    check("t6_restart_clear", 32'(done), 32'd0);
    repeat (9) @(negedge clk);
    run_len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, 20, "t6_ign");
    check("t6_ign_pass", 32'(pass), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
